// File: rtl/cam_sccb_config.sv
// rtl/cam_sccb_config.sv - power-up SCCB register-table sequencer for an OV7670-class camera
//
// Walks an external synchronous register table and issues one SCCB 3-phase write
// (DEV_ID, reg, val) per entry. Table entries 16'hFFFF end the table early and
// entries with reg == 8'hFE insert a fixed delay instead of a bus write.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   start      single-cycle pulse, re-runs the table from index 0 when done
//   rom_addr   table index
//   rom_data   {reg, val}, valid one cycle after rom_addr changes
//   sio_c      SCCB clock
//   sio_d_out  SCCB data value
//   sio_d_oe   1 = drive sio_d_out, 0 = release (pad pulled high)
//   busy       high while the sequencer is working
//   cfg_done   high once the table has been fully written
//   entry_cnt  entries written in the current run (saturating)
module cam_sccb_config #(
    parameter int         CLK_DIV      = 125,
    parameter int         NUM_REGS     = 64,
    parameter logic [7:0] DEV_ID       = 8'h42,
    parameter int         PWRUP_WAIT   = 50000,
    parameter int         DELAY_CYCLES = 500000,
    parameter int         GAP_Q        = 4,
    localparam int        AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          sio_c,
    output logic          sio_d_out,
    output logic          sio_d_oe,
    output logic          busy,
    output logic          cfg_done,
    output logic [7:0]    entry_cnt
);

    localparam int WAIT_MAX = (PWRUP_WAIT > DELAY_CYCLES) ? PWRUP_WAIT : DELAY_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 2);
    localparam int QCW      = $clog2(CLK_DIV + 1);
    localparam int QIW      = (GAP_Q > 4) ? $clog2(GAP_Q) : 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_START,
        S_BITS,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [QCW-1:0]    qcnt;
    logic [QIW-1:0]    qidx;
    logic [4:0]        bit_idx;
    logic [7:0]        reg_r;
    logic [7:0]        val_r;

    logic        quarter_state;
    logic        tick;
    logic        q_last;
    logic        gap_last;
    logic        phase_done;
    logic        fetch_done;
    logic        pwrup_done;
    logic        delay_done;
    logic        last_index;
    logic        advance;
    logic [26:0] frame;

    assign quarter_state = (state == S_START) || (state == S_BITS) ||
                           (state == S_STOP)  || (state == S_GAP);
    assign tick          = quarter_state && (qcnt == QCW'(CLK_DIV - 1));
    assign q_last        = (qidx == QIW'(3));
    assign gap_last      = (qidx == QIW'(GAP_Q - 1));
    // GAP is the only phase whose length is not four quarters.
    assign phase_done    = tick && ((state == S_GAP) ? gap_last : q_last);
    // rom_data reflects rom_addr from the second FETCH cycle on.
    assign fetch_done    = (state == S_FETCH) && (wait_cnt == WAIT_W'(1));
    assign pwrup_done    = (wait_cnt == WAIT_W'(PWRUP_WAIT - 1));
    assign delay_done    = (wait_cnt == WAIT_W'(DELAY_CYCLES - 1));
    assign last_index    = (rom_addr == AW'(NUM_REGS - 1));
    assign advance       = ((state == S_GAP) && phase_done) ||
                           ((state == S_DELAY) && delay_done);

    // Whole write frame, MSB first; the 1s stand in for the released ack slots.
    assign frame = {DEV_ID, 1'b1, reg_r, 1'b1, val_r, 1'b1};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_PWRUP;
            S_PWRUP: if (pwrup_done) state_nxt = S_FETCH;
            S_FETCH: begin
                if (fetch_done) begin
                    if (rom_data == 16'hFFFF) begin
                        state_nxt = S_DONE;
                    end else if (rom_data[15:8] == 8'hFE) begin
                        state_nxt = S_DELAY;
                    end else begin
                        state_nxt = S_START;
                    end
                end
            end
            S_START: if (phase_done) state_nxt = S_BITS;
            S_BITS:  if (phase_done && (bit_idx == 5'd26)) state_nxt = S_STOP;
            S_STOP:  if (phase_done) state_nxt = S_GAP;
            S_GAP,
            S_DELAY: if (advance) state_nxt = last_index ? S_DONE : S_FETCH;
            S_DONE:  if (start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters and table registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            qcnt      <= '0;
            qidx      <= '0;
            bit_idx   <= '0;
            reg_r     <= '0;
            val_r     <= '0;
            rom_addr  <= '0;
            entry_cnt <= '0;
        end else begin
            if ((state_nxt == state) &&
                ((state == S_PWRUP) || (state == S_FETCH) || (state == S_DELAY))) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (quarter_state && !tick) begin
                qcnt <= qcnt + QCW'(1);
            end else begin
                qcnt <= '0;
            end

            if (!quarter_state || phase_done) begin
                qidx <= '0;
            end else if (tick) begin
                qidx <= qidx + QIW'(1);
            end

            if (state != S_BITS) begin
                bit_idx <= '0;
            end else if (phase_done) begin
                bit_idx <= bit_idx + 5'd1;
            end

            if (fetch_done) begin
                reg_r <= rom_data[15:8];
                val_r <= rom_data[7:0];
            end

            if ((state == S_PWRUP) || ((state == S_DONE) && start)) begin
                rom_addr <= '0;
            end else if (advance && !last_index) begin
                rom_addr <= rom_addr + AW'(1);
            end

            if ((state == S_DONE) && start) begin
                entry_cnt <= '0;
            end else if ((state == S_GAP) && phase_done && (entry_cnt != 8'hFF)) begin
                entry_cnt <= entry_cnt + 8'd1;
            end
        end
    end

    // Outputs; bus idles high everywhere except START, BITS and STOP.
    always_comb begin
        sio_c     = 1'b1;
        sio_d_out = 1'b1;
        sio_d_oe  = 1'b1;
        busy      = (state != S_IDLE) && (state != S_DONE);
        cfg_done  = (state == S_DONE);
        case (state)
            S_START: begin
                sio_c     = ~qidx[1];
                sio_d_out = (qidx[1:0] == 2'd0);
            end
            S_BITS: begin
                // Data follows bit_idx, so it changes only as quarter 0 begins.
                sio_c     = qidx[1];
                sio_d_out = frame[5'd26 - bit_idx];
                sio_d_oe  = !((bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26));
            end
            S_STOP: begin
                sio_c     = (qidx[1:0] != 2'd0);
                sio_d_out = qidx[1];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cam_sccb_config.sv
// tb/tb_cam_sccb_config.sv - self-checking bench for cam_sccb_config
module tb_cam_sccb_config;

    localparam int CLK_DIV      = 2;
    localparam int NUM_REGS     = 4;
    localparam int PWRUP_WAIT   = 10;
    localparam int DELAY_CYCLES = 100;
    localparam int GAP_Q        = 4;
    localparam logic [26:0] OE_EXP = 27'b111111110_111111110_111111110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        sio_c;
    logic        sio_d_out;
    logic        sio_d_oe;
    logic        busy;
    logic        cfg_done;
    logic [7:0]  entry_cnt;

    cam_sccb_config #(
        .CLK_DIV      (CLK_DIV),
        .NUM_REGS     (NUM_REGS),
        .DEV_ID       (8'h42),
        .PWRUP_WAIT   (PWRUP_WAIT),
        .DELAY_CYCLES (DELAY_CYCLES),
        .GAP_Q        (GAP_Q)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sio_c     (sio_c),
        .sio_d_out (sio_d_out),
        .sio_d_oe  (sio_d_oe),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .entry_cnt (entry_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [NUM_REGS];
    always @(posedge clk) rom_data <= tbl[rom_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Bus monitor: decodes SCCB writes and flags protocol violations.
    typedef struct {
        logic [26:0] bits;
        logic [26:0] oe;
    } rx_t;

    rx_t         rx[$];
    int          gaps[$];
    int          viol = 0;
    int          done_rises = 0;
    int          cyc = 0;
    int          bitcnt = 0;
    int          hcnt = 0;
    int          stop_cyc = 0;
    bit          in_txn = 0;
    bit          have_stop = 0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        prev_done = 1'b0;
    logic [26:0] shreg = '0;
    logic [26:0] oem = '0;

    initial begin
        logic sda;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                in_txn    = 0;
                bitcnt    = 0;
                prev_scl  = 1'b1;
                prev_sda  = 1'b1;
                prev_done = cfg_done;
            end else begin
                sda = sio_d_oe ? sio_d_out : 1'b1;
                if (prev_scl && sio_c && (sda != prev_sda)) begin
                    if (!sda && !in_txn) begin
                        in_txn = 1;
                        bitcnt = 0;
                        if (have_stop) gaps.push_back(cyc - stop_cyc);
                    end else if (sda && in_txn && bitcnt == 27) begin
                        in_txn    = 0;
                        rx.push_back('{bits: shreg, oe: oem});
                        stop_cyc  = cyc;
                        have_stop = 1;
                    end else begin
                        viol++;
                    end
                end
                if (!prev_scl && sio_c) begin
                    hcnt = 1;
                    if (in_txn && bitcnt < 27) begin
                        shreg = {shreg[25:0], sda};
                        oem   = {oem[25:0], sio_d_oe};
                        bitcnt++;
                    end
                end else if (sio_c) begin
                    hcnt++;
                end
                if (prev_scl && !sio_c) begin
                    if (!in_txn) viol++;
                    else if (bitcnt > 0 && hcnt != 2 * CLK_DIV) viol++;
                end
                if (cfg_done && !prev_done) done_rises++;
                prev_scl  = sio_c;
                prev_sda  = sda;
                prev_done = cfg_done;
            end
        end
    end

    task automatic clear_mon();
        rx.delete();
        gaps.delete();
        viol       = 0;
        done_rises = 0;
        have_stop  = 0;
    endtask

    // Reference model: walks the table by the sequencing rules.
    logic [15:0] exp_q[$];
    int          exp_gaps[$];
    int          exp_total;
    int          exp_addr;

    task automatic model();
        int ndel;
        bit first;
        exp_q.delete();
        exp_gaps.delete();
        exp_total = 0;
        exp_addr  = 0;
        ndel      = 0;
        first     = 1;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_addr  = i;
            exp_total += 2;
            if (tbl[i] == 16'hFFFF) break;
            if (tbl[i][15:8] == 8'hFE) begin
                exp_total += DELAY_CYCLES;
                ndel++;
            end else begin
                exp_total += (116 + GAP_Q) * CLK_DIV;
                if (!first) exp_gaps.push_back((3 + GAP_Q) * CLK_DIV + 2 + ndel * (2 + DELAY_CYCLES));
                first = 0;
                ndel  = 0;
                exp_q.push_back(tbl[i]);
            end
        end
    endtask

    task automatic check_content(input string nm);
        chk({nm, " protocol_viol"}, viol, 0);
        chk({nm, " done_rises"}, done_rises, 1);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " entry_cnt"}, entry_cnt, exp_q.size());
        chk({nm, " rom_addr"}, rom_addr, exp_addr);
        chk({nm, " ntxn"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
            chk({nm, " dev_id"}, rx[i].bits[26:19], 8'h42);
            chk({nm, " reg_val"}, {rx[i].bits[17:10], rx[i].bits[8:1]}, exp_q[i]);
            chk({nm, " oe_mask"}, rx[i].oe, OE_EXP);
        end
        chk({nm, " ngaps"}, gaps.size(), exp_gaps.size());
        for (int i = 0; i < gaps.size() && i < exp_gaps.size(); i++) begin
            chk({nm, " gap"}, gaps[i], exp_gaps[i]);
        end
    endtask

    task automatic run_start(input bit inject, output int n);
        @(negedge clk);
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!cfg_done && n < 6000) begin
            @(negedge clk);
            n++;
            if (inject && n == 40) start = 1'b1;
            if (inject && n == 41) start = 1'b0;
        end
    endtask

    task automatic run_release(output int fall, output int n);
        clear_mon();
        @(negedge clk);
        reset = 1'b1;
        n     = 0;
        fall  = -1;
        while (!cfg_done && n < 6000) begin
            @(negedge clk);
            n++;
            if (fall < 0 && !sio_c) fall = n;
        end
    endtask

    typedef struct {
        logic [15:0] t [NUM_REGS];
        int          cyc;
        int          ntxn;
        int          addr;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input int cy, input int nt, input int ad);
        vecs[i].t[0] = a;
        vecs[i].t[1] = b;
        vecs[i].t[2] = c;
        vecs[i].t[3] = d;
        vecs[i].cyc  = cy;
        vecs[i].ntxn = nt;
        vecs[i].addr = ad;
    endtask

    initial begin
        int n;
        int fall;
        // Cycles counted from the start pulse: plain entry 242, delay entry 102,
        // end marker 2, plus the cycle in which start is taken.
        set_vec(0, 16'h1280, 16'hFE00, 16'h3A04, 16'hFFFF, 589, 2, 3);
        set_vec(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 969, 4, 3);
        set_vec(2, 16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC, 3,   0, 0);
        set_vec(3, 16'hFE00, 16'hFE55, 16'hFFFF, 16'h0000, 207, 0, 2);
        set_vec(4, 16'h0A0B, 16'h8C0D, 16'hFE00, 16'h7FFF, 829, 3, 3);
        set_vec(5, 16'hFFFE, 16'hFFFF, 16'hAAAA, 16'hBBBB, 245, 1, 1);
        set_vec(6, 16'hFEFF, 16'h00FF, 16'hFF00, 16'hFE01, 689, 2, 3);

        tbl[0] = 16'h1280;
        tbl[1] = 16'hFFFF;
        tbl[2] = 16'h0000;
        tbl[3] = 16'h0000;

        #3 reset = 1'b0;
        #1;
        chk("reset sio_c", sio_c, 1);
        chk("reset sio_d_out", sio_d_out, 1);
        chk("reset sio_d_oe", sio_d_oe, 1);
        chk("reset busy", busy, 0);
        chk("reset cfg_done", cfg_done, 0);
        chk("reset entry_cnt", entry_cnt, 0);
        chk("reset rom_addr", rom_addr, 0);
        repeat (3) @(negedge clk);

        // Power-up run: IDLE cycle, PWRUP, 2 FETCH cycles, then two START quarters.
        model();
        run_release(fall, n);
        chk("pwrup first_fall", fall, 1 + PWRUP_WAIT + 2 + 2 * CLK_DIV);
        chk("pwrup done_cycles", n, 1 + PWRUP_WAIT + 2 + 120 * CLK_DIV + 2);
        check_content("pwrup");

        foreach (vecs[v]) begin
            for (int i = 0; i < NUM_REGS; i++) tbl[i] = vecs[v].t[i];
            model();
            run_start(1'b0, n);
            chk($sformatf("vec%0d done_cycles", v), n, vecs[v].cyc);
            chk($sformatf("vec%0d entry_cnt", v), entry_cnt, vecs[v].ntxn);
            chk($sformatf("vec%0d rom_addr", v), rom_addr, vecs[v].addr);
            check_content($sformatf("vec%0d", v));
        end

        // start during BITS is ignored
        for (int i = 0; i < NUM_REGS; i++) tbl[i] = vecs[0].t[i];
        model();
        run_start(1'b1, n);
        chk("ignore_start done_cycles", n, vecs[0].cyc);
        check_content("ignore_start");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                logic [7:0] rg;
                logic [7:0] vl;
                int         k;
                k  = $urandom_range(0, 7);
                rg = 8'($urandom);
                vl = 8'($urandom);
                if (k == 0) begin
                    tbl[i] = 16'hFFFF;
                end else if (k == 1) begin
                    tbl[i] = {8'hFE, vl};
                end else begin
                    if (rg == 8'hFE) rg = 8'h12;
                    if ({rg, vl} == 16'hFFFF) vl = 8'hFE;
                    tbl[i] = {rg, vl};
                end
            end
            model();
            run_start(1'b0, n);
            chk($sformatf("rand%0d done_cycles", r), n, exp_total + 1);
            check_content($sformatf("rand%0d", r));
        end

        // Reset during bit 14 of transaction 1, then a full rerun from index 0.
        for (int i = 0; i < NUM_REGS; i++) tbl[i] = vecs[1].t[i];
        @(negedge clk);
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(rx.size() == 1 && in_txn && bitcnt == 14) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached_bit14", n < 3000, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort sio_c", sio_c, 1);
        chk("abort sio_d_out", sio_d_out, 1);
        chk("abort sio_d_oe", sio_d_oe, 1);
        chk("abort busy", busy, 0);
        chk("abort cfg_done", cfg_done, 0);
        repeat (3) @(negedge clk);
        model();
        run_release(fall, n);
        chk("abort first_fall", fall, 1 + PWRUP_WAIT + 2 + 2 * CLK_DIV);
        chk("abort done_cycles", n, 1 + PWRUP_WAIT + exp_total);
        check_content("abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
